// File: rtl/fetch_unit_if.sv
// fetch_unit_if: signal bundle between the fetch stage, instruction memory and the pipeline
`timescale 1ns/1ps
interface fetch_unit_if;
  logic [1:0]  pc_sel_i;
  logic [31:0] target_i;
  logic        stall_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_valid_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        squash_o;
  logic        misalign_o;
  logic [15:0] bubble_cnt_o;
  modport master (
    input  pc_sel_i, target_i, stall_i, imem_rdata_i, imem_valid_i,
    output imem_addr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, squash_o, misalign_o, bubble_cnt_o
  );
  modport slave (
    output pc_sel_i, target_i, stall_i, imem_rdata_i, imem_valid_i,
    input  imem_addr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, squash_o, misalign_o, bubble_cnt_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, redirect squash and IF/ID register of an in-order fetch stage
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          FLUSH_SLOTS = 2
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);
  localparam logic [0:0] RUN         = 1'b0;
  localparam logic [0:0] SQUASH      = 1'b1;
  localparam logic [1:0] CNT_LOAD    = 2'(FLUSH_SLOTS - 1);
  localparam logic [0:0] REDIR_STATE = (FLUSH_SLOTS == 1) ? RUN : SQUASH;
  logic [0:0]  state;
  logic [1:0]  cnt;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign;
  logic [15:0] bubble_cnt;
  logic        redirect;
  logic        bubble;
  logic [31:0] tgt_j;
  // classify the cycle: redirect beats stall, and every unstalled non-fetch cycle is a bubble
  always_comb begin
    redirect = (bus.pc_sel_i == 2'd1) || (bus.pc_sel_i == 2'd2);
    tgt_j    = (bus.pc_sel_i == 2'd2) ? {bus.target_i[31:1], 1'b0} : bus.target_i;
    bubble   = redirect || (!bus.stall_i && ((state == SQUASH) || !bus.imem_valid_i));
  end
  // PC and squash sequencing; PC only advances on a real fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
      cnt   <= 2'd0;
    end else if (redirect) begin
      pc    <= {tgt_j[31:2], 2'b00};
      state <= REDIR_STATE;
      cnt   <= CNT_LOAD;
    end else if (!bus.stall_i) begin
      if (state == SQUASH) begin
        state <= (cnt <= 2'd1) ? RUN : SQUASH;
        cnt   <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
      end else if (bus.imem_valid_i) begin
        pc <= pc + 32'd4;
      end
    end
  end
  // IF/ID register: real instruction on a fetch, NOP bubble otherwise, frozen on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect || !bus.stall_i) begin
      if_id_pc    <= pc;
      if_id_instr <= bubble ? NOP_INSTR : bus.imem_rdata_i;
      if_id_valid <= !bubble;
    end
  end
  // sticky misalignment flag and saturating bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign   <= 1'b0;
      bubble_cnt <= 16'd0;
    end else begin
      if (redirect && (tgt_j[1:0] != 2'b00)) misalign <= 1'b1;
      if (bubble && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
  assign bus.imem_addr_o   = pc;
  assign bus.squash_o      = (state == SQUASH);
  assign bus.if_id_pc_o    = if_id_pc;
  assign bus.if_id_instr_o = if_id_instr;
  assign bus.if_id_valid_o = if_id_valid;
  assign bus.misalign_o    = misalign;
  assign bus.bubble_cnt_o  = bubble_cnt;
endmodule
